// File: rtl/mem_port_arbiter.sv
// Arbitrates the single data-memory port between the CPU memory stage and a DMA/loader requester.
// Optional MEM_ARB_STATS_EN adds the stall_cycles and dma_grants saturating counters.
//
// state     | meaning
// ----------|------------------------------------------------------------
// CPU_PRI   | CPU wins conflicts until the DMA has starved STARVE_LIMIT cycles
// DMA_BURST | forced DMA burst in progress, CPU frozen while DMA requests
module mem_port_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int BURST_MAX    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cpu_mem_write_en,
  input  logic        cpu_mem_read_en,
  input  logic [31:0] cpu_mem_addr,
  input  logic [31:0] cpu_mem_write_data,
  output logic [31:0] cpu_mem_read_data,
  output logic        cpu_stall,
  input  logic        dma_req,
  input  logic [3:0]  dma_we,
  input  logic [31:0] dma_addr,
  input  logic [31:0] dma_wdata,
  output logic        dma_gnt,
  output logic        dma_rvalid,
  output logic [31:0] dma_rdata,
  output logic [3:0]  mem_write_en,
  output logic        mem_read_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0] stall_cycles,
  output logic [31:0] dma_grants
`endif
);

  localparam int SW = (STARVE_LIMIT > 1) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int BW = (BURST_MAX > 1) ? $clog2(BURST_MAX + 1) : 1;

  localparam logic [0:0] CPU_PRI   = 1'b0;
  localparam logic [0:0] DMA_BURST = 1'b1;

  logic [0:0]    state, state_nxt;
  logic [SW-1:0] starve_cnt;
  logic [BW-1:0] burst_cnt, burst_nxt, burst_inc;
  logic          cpu_rd_pend, dma_rd_pend;
  logic          hold_vld;
  logic [31:0]   hold_data;

  logic cpu_req, dma_rd, starve_hit, forced;
  logic dma_win, cpu_win, gnt_dma, gnt_cpu;

  assign cpu_req    = (|cpu_mem_write_en) | cpu_mem_read_en;
  assign dma_rd     = dma_req & (dma_we == 4'h0);
  assign starve_hit = (starve_cnt == SW'(STARVE_LIMIT));
  assign forced     = (state == CPU_PRI) & dma_req & cpu_req & starve_hit;
  assign burst_inc  = burst_cnt + BW'(1);

  always_comb begin
    dma_win = 1'b0;
    case (state)
      CPU_PRI:   dma_win = dma_req & (~cpu_req | starve_hit);
      DMA_BURST: dma_win = dma_req;
      default:   dma_win = 1'b0;
    endcase
  end

  assign cpu_win = cpu_req & ~dma_win;

  always_comb begin
    state_nxt = state;
    burst_nxt = burst_cnt;
    case (state)
      CPU_PRI: begin
        if (forced) begin
          burst_nxt = BW'(1);
          state_nxt = (BURST_MAX > 1) ? DMA_BURST : CPU_PRI;
        end
      end
      DMA_BURST: begin
        if (!dma_req) begin
          state_nxt = CPU_PRI;
        end else begin
          burst_nxt = burst_inc;
          if (burst_inc == BW'(BURST_MAX))
            state_nxt = CPU_PRI;
        end
      end
      default: state_nxt = CPU_PRI;
    endcase
  end

  // Qualify with rst_n so every output reads zero for the whole reset window.
  assign gnt_dma = rst_n & dma_win;
  assign gnt_cpu = rst_n & cpu_win;

  always_comb begin
    mem_write_en   = 4'h0;
    mem_read_en    = 1'b0;
    mem_addr       = 32'h0;
    mem_write_data = 32'h0;
    if (gnt_dma) begin
      mem_write_en   = dma_we;
      mem_read_en    = (dma_we == 4'h0);
      mem_addr       = dma_addr;
      mem_write_data = dma_wdata;
    end else if (gnt_cpu) begin
      mem_write_en   = cpu_mem_write_en;
      mem_read_en    = cpu_mem_read_en;
      mem_addr       = cpu_mem_addr;
      mem_write_data = cpu_mem_write_data;
    end
  end

  assign dma_gnt    = gnt_dma;
  assign cpu_stall  = rst_n & cpu_req & dma_win;
  assign dma_rvalid = dma_rd_pend;
  assign dma_rdata  = dma_rd_pend ? mem_read_data : 32'h0;

  always_comb begin
    cpu_mem_read_data = 32'h0;
    if (rst_n)
      cpu_mem_read_data = hold_vld ? hold_data : mem_read_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= CPU_PRI;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (dma_gnt) begin
      starve_cnt <= '0;
    end else if (dma_req && !starve_hit) begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

  // A CPU load landing during a stall is parked until the CPU is released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rd_pend <= 1'b0;
      dma_rd_pend <= 1'b0;
      hold_vld    <= 1'b0;
      hold_data   <= 32'h0;
    end else begin
      cpu_rd_pend <= gnt_cpu & cpu_mem_read_en;
      dma_rd_pend <= dma_gnt & dma_rd;
      if (cpu_rd_pend && cpu_stall) begin
        hold_data <= mem_read_data;
        hold_vld  <= 1'b1;
      end else if (!cpu_stall) begin
        hold_vld  <= 1'b0;
      end
    end
  end

`ifdef MEM_ARB_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= 32'h0;
      dma_grants   <= 32'h0;
    end else begin
      if (cpu_stall && (stall_cycles != 32'hFFFF_FFFF))
        stall_cycles <= stall_cycles + 32'd1;
      if (dma_gnt && (dma_grants != 32'hFFFF_FFFF))
        dma_grants <= dma_grants + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a 1-cycle-latency RAM model on the memory side.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  cpu_mem_write_en;
  logic        cpu_mem_read_en;
  logic [31:0] cpu_mem_addr;
  logic [31:0] cpu_mem_write_data;
  logic [31:0] cpu_mem_read_data;
  logic        cpu_stall;
  logic        dma_req;
  logic [3:0]  dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic        dma_gnt;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic [3:0]  mem_write_en;
  logic        mem_read_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data = 32'h0;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] dma_grants;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  mem_port_arbiter #(.STARVE_LIMIT(8), .BURST_MAX(4)) dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .cpu_mem_write_en   (cpu_mem_write_en),
    .cpu_mem_read_en    (cpu_mem_read_en),
    .cpu_mem_addr       (cpu_mem_addr),
    .cpu_mem_write_data (cpu_mem_write_data),
    .cpu_mem_read_data  (cpu_mem_read_data),
    .cpu_stall          (cpu_stall),
    .dma_req            (dma_req),
    .dma_we             (dma_we),
    .dma_addr           (dma_addr),
    .dma_wdata          (dma_wdata),
    .dma_gnt            (dma_gnt),
    .dma_rvalid         (dma_rvalid),
    .dma_rdata          (dma_rdata),
    .mem_write_en       (mem_write_en),
    .mem_read_en        (mem_read_en),
    .mem_addr           (mem_addr),
    .mem_write_data     (mem_write_data),
    .mem_read_data      (mem_read_data)
`ifdef MEM_ARB_STATS_EN
    ,
    .stall_cycles       (stall_cycles),
    .dma_grants         (dma_grants)
`endif
  );

  always #5 clk = ~clk;

  // RAM returns 0 on cycles without a read so a held CPU load is distinguishable.
  logic [31:0] ram [0:255];
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (mem_write_en[b]) ram[mem_addr[9:2]][8*b +: 8] <= mem_write_data[8*b +: 8];
    mem_read_data <= mem_read_en ? ram[mem_addr[9:2]] : 32'h0;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
  endtask

  task automatic idle();
    cpu_mem_write_en   = 4'h0;
    cpu_mem_read_en    = 1'b0;
    cpu_mem_addr       = 32'h0;
    cpu_mem_write_data = 32'h0;
    dma_req            = 1'b0;
    dma_we             = 4'h0;
    dma_addr           = 32'h0;
    dma_wdata          = 32'h0;
  endtask

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic dma_write(input logic [31:0] a, input logic [31:0] d);
    dma_req = 1'b1; dma_we = 4'hF; dma_addr = a; dma_wdata = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"},  mem_addr, 32'h0);
    chk({tag, "_wen"},   {28'h0, mem_write_en}, 32'h0);
    chk({tag, "_ren"},   {31'h0, mem_read_en}, 32'h0);
    chk({tag, "_gnt"},   {31'h0, dma_gnt}, 32'h0);
    chk({tag, "_rvld"},  {31'h0, dma_rvalid}, 32'h0);
    chk({tag, "_stall"}, {31'h0, cpu_stall}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] pre_addr [4];
    logic [31:0] pre_data [4];
    logic [31:0] exp_addr;
    logic        exp_dma;
    pre_addr = '{32'h200, 32'h100, 32'h40, 32'h80};
    pre_data = '{32'hDEADBEEF, 32'h12345678, 32'hCAFEF00D, 32'hAAAA5555};

    // reset with requests present: outputs must stay quiet
    idle();
    rst_n = 1'b0;
    #1;
    cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h100;
    dma_write(32'h200, 32'h1);
    #2;
    chk_all_zero("rst");
    idle();
    repeat (2) @(posedge clk);
    mid();
    rst_n = 1'b1;
    to_next();

    // DMA-only writes; the first is the 0x200 case, the rest preload RAM
    for (int i = 0; i < 4; i++) begin
      dma_write(pre_addr[i], pre_data[i]);
      mid();
      chk("pre_gnt", {31'h0, dma_gnt}, 32'h1);
      if (i == 0) begin
        chk("dw_wen",   {28'h0, mem_write_en}, 32'hF);
        chk("dw_wdata", mem_write_data, 32'hDEADBEEF);
        chk("dw_addr",  mem_addr, 32'h200);
        chk("dw_stall", {31'h0, cpu_stall}, 32'h0);
      end
      to_next();
      idle();
    end

    // CPU-only load
    cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h100;
    mid();
    chk("cl_addr",  mem_addr, 32'h100);
    chk("cl_ren",   {31'h0, mem_read_en}, 32'h1);
    chk("cl_stall", {31'h0, cpu_stall}, 32'h0);
    to_next();
    idle();
    mid();
    chk("cl_data",   cpu_mem_read_data, 32'h12345678);
    chk("cl_stall2", {31'h0, cpu_stall}, 32'h0);
    to_next();

    // DMA reads: 0x40 preloaded, 0x200 written by DMA earlier
    for (int i = 0; i < 2; i++) begin
      dma_req = 1'b1; dma_we = 4'h0; dma_addr = (i == 0) ? 32'h40 : 32'h200;
      mid();
      chk("dr_gnt",  {31'h0, dma_gnt}, 32'h1);
      chk("dr_rvld0", {31'h0, dma_rvalid}, 32'h0);
      to_next();
      idle();
      mid();
      chk("dr_rvld1", {31'h0, dma_rvalid}, 32'h1);
      chk("dr_rdata", dma_rdata, (i == 0) ? 32'hCAFEF00D : 32'hDEADBEEF);
      to_next();
      mid();
      chk("dr_rvld2", {31'h0, dma_rvalid}, 32'h0);
      chk("dr_rdata0", dma_rdata, 32'h0);
      to_next();
    end

    // continuous conflict: CPU 1-8 (load on 8), forced DMA burst 9-12, CPU 13
    for (int k = 1; k <= 13; k++) begin
      dma_write(32'h310, 32'h5A5A5A5A);
      if (k <= 7) begin
        cpu_mem_write_en = 4'hF; cpu_mem_read_en = 1'b0;
        cpu_mem_addr = 32'h300; cpu_mem_write_data = k;
      end else if (k == 8) begin
        cpu_mem_write_en = 4'h0; cpu_mem_read_en = 1'b1; cpu_mem_addr = 32'h80;
      end else begin
        cpu_mem_write_en = 4'hF; cpu_mem_read_en = 1'b0;
        cpu_mem_addr = 32'h304; cpu_mem_write_data = 32'h99;
      end
      exp_dma  = (k >= 9) && (k <= 12);
      exp_addr = exp_dma ? 32'h310 : (k <= 7) ? 32'h300 : (k == 8) ? 32'h80 : 32'h304;
      mid();
      chk($sformatf("cf%0d_gnt", k),   {31'h0, dma_gnt}, {31'h0, exp_dma});
      chk($sformatf("cf%0d_stall", k), {31'h0, cpu_stall}, {31'h0, exp_dma});
      chk($sformatf("cf%0d_addr", k),  mem_addr, exp_addr);
      chk($sformatf("cf%0d_wen", k),   {28'h0, mem_write_en}, (k == 8) ? 32'h0 : 32'hF);
      chk($sformatf("cf%0d_ren", k),   {31'h0, mem_read_en}, (k == 8) ? 32'h1 : 32'h0);
      if (k >= 9) chk($sformatf("cf%0d_hold", k), cpu_mem_read_data, 32'hAAAA5555);
      to_next();
    end
    cpu_mem_write_en = 4'h0;
    mid();
    chk("post_gnt",   {31'h0, dma_gnt}, 32'h1);
    chk("post_stall", {31'h0, cpu_stall}, 32'h0);
    chk("post_rdata", cpu_mem_read_data, 32'h0);
    to_next();
    idle();
    to_next();

    // reset on burst cycle 2 with a DMA read pending
    for (int k = 1; k <= 10; k++) begin
      dma_req = 1'b1; dma_we = 4'h0; dma_addr = 32'h40;
      cpu_mem_write_en = 4'hF; cpu_mem_addr = 32'h300; cpu_mem_write_data = 32'h77;
      if (k == 10) begin
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("mrst");
        chk("mrst_cpu_rdata", cpu_mem_read_data, 32'h0);
      end else begin
        mid();
        chk($sformatf("rb%0d_gnt", k), {31'h0, dma_gnt}, (k == 9) ? 32'h1 : 32'h0);
      end
      to_next();
    end
    #2 rst_n = 1'b1;
    mid();
    chk("ar_gnt",   {31'h0, dma_gnt}, 32'h0);
    chk("ar_stall", {31'h0, cpu_stall}, 32'h0);
    chk("ar_addr",  mem_addr, 32'h300);
    chk("ar_rvld",  {31'h0, dma_rvalid}, 32'h0);
    to_next();
    idle();
    mid();
    chk("ar_rvld2", {31'h0, dma_rvalid}, 32'h0);
    to_next();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
